fir_mac_param: RTL

Parametrised sequential-MAC FIR engine. It is the next generation of the FIR_main core: data, coefficient and address widths are generic, three output-length modes are supported, and rounding, saturation with a saturation counter, config-error detection and abort are added. It sits between a synchronous-read coefficient RAM, a synchronous-read sample RAM and a result RAM; control comes from the host/CDC logic via start/busy/done. Samples, coefficients and results are signed fixed point with FRAC fractional bits (Q15 by default).

---
 rtl/fir_mac_param_if.sv | 36 +++
 rtl/fir_mac_param.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_param_if.sv
// Bus bundle for fir_mac_param: host control/status plus the coefficient,
// sample and result RAM ports. The engine connects through the slave modport.
interface fir_mac_param_if #(
   parameter int DW      = 16,
   parameter int CW      = 16,
   parameter int COEF_AW = 5,
   parameter int SAMP_AW = 13
);
   logic                 start;
   logic                 abort;
   logic [1:0]           mode;
   logic                 round_en;
   logic [COEF_AW:0]     n_coef;
   logic [SAMP_AW:0]     n_samp;
   logic [COEF_AW-1:0]   coef_addr;
   logic signed [CW-1:0] coef_data;
   logic [SAMP_AW-1:0]   samp_addr;
   logic signed [DW-1:0] samp_data;
   logic [SAMP_AW:0]     out_addr;
   logic signed [DW-1:0] out_data;
   logic                 out_wr;
   logic                 busy;
   logic                 done;
   logic                 err;
   logic [15:0]          sat_cnt;

   modport master (
      output start, abort, mode, round_en, n_coef, n_samp, coef_data, samp_data,
      input  coef_addr, samp_addr, out_addr, out_data, out_wr, busy, done, err, sat_cnt
   );

   modport slave (
      input  start, abort, mode, round_en, n_coef, n_samp, coef_data, samp_data,
      output coef_addr, samp_addr, out_addr, out_data, out_wr, busy, done, err, sat_cnt
   );
endinterface

// File: rtl/fir_mac_param.sv
// Sequential single-MAC FIR engine: one tap per cycle from synchronous-read RAMs,
// full/valid/same output lengths, round-or-floor, saturation with a clamp counter.
module fir_mac_param #(
   parameter int DW      = 16,
   parameter int CW      = 16,
   parameter int COEF_AW = 5,
   parameter int SAMP_AW = 13,
   parameter int FRAC    = 15,
   parameter int ACCW    = DW + CW + COEF_AW
) (
   input logic            clk,
   input logic            rst_n,
   fir_mac_param_if.slave bus
);
   localparam int JW  = COEF_AW + 1;
   localparam int KW  = SAMP_AW + 2;
   localparam int PW  = DW + CW;
   localparam int OAW = SAMP_AW + 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam logic signed [ACCW-1:0] SMAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [ACCW-1:0] SMIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   // First tap index contributing to output kk: max(0, kk-N+1).
   function automatic logic [KW-1:0] tap_lo(input logic [KW-1:0] kk, input logic [KW-1:0] nn);
      return (kk >= nn) ? kk - nn + KW'(1) : '0;
   endfunction

   // Last tap index contributing to output kk: min(M-1, kk).
   function automatic logic [KW-1:0] tap_hi(input logic [KW-1:0] kk, input logic [KW-1:0] mm);
      return (kk < mm - KW'(1)) ? kk : mm - KW'(1);
   endfunction

   function automatic logic signed [ACCW-1:0] round_acc(input logic signed [ACCW-1:0] a,
                                                       input logic en);
      logic signed [ACCW-1:0] bias;
      bias = '0;
      bias[FRAC-1] = en;
      return (a + bias) >>> FRAC;
   endfunction

   function automatic logic clamped(input logic signed [ACCW-1:0] r);
      return (r > SMAX) || (r < SMIN);
   endfunction

   function automatic logic signed [DW-1:0] sat_dw(input logic signed [ACCW-1:0] r);
      if (r > SMAX) return SMAX[DW-1:0];
      if (r < SMIN) return SMIN[DW-1:0];
      return r[DW-1:0];
   endfunction

   logic [2:0]             state;
   logic [1:0]             mode_r;
   logic                   rnd_r;
   logic [KW-1:0]          m_r;
   logic [KW-1:0]          n_r;
   logic [KW-1:0]          k;
   logic [JW-1:0]          j;
   logic                   vld_p1;
   logic signed [PW-1:0]   prod_p1;
   logic signed [ACCW-1:0] acc_p2;
   logic signed [ACCW-1:0] sum_p2;
   logic signed [ACCW-1:0] rnd_p2;
   logic [KW-1:0]          k_nxt;
   logic [KW-1:0]          lo_cur;
   logic [KW-1:0]          lo_nxt;
   logic [KW-1:0]          j_hi;
   logic [KW-1:0]          k_last;
   logic [KW-1:0]          base;
   logic [KW-1:0]          k_first;
   logic                   cfg_bad;

   always_comb begin
      // p1: RAM data for the pair issued last cycle
      prod_p1 = PW'(bus.coef_data) * PW'(bus.samp_data);
      // p2: accumulate, then scale back to DW
      sum_p2  = acc_p2 + ACCW'(prod_p1);
      rnd_p2  = round_acc(sum_p2, rnd_r);
      k_nxt   = k + KW'(1);
      lo_cur  = tap_lo(k, n_r);
      lo_nxt  = tap_lo(k_nxt, n_r);
      j_hi    = tap_hi(k, m_r);
      k_last  = (mode_r == 2'b00) ? n_r + m_r - KW'(2) : n_r - KW'(1);
      base    = (mode_r == 2'b01) ? m_r - KW'(1) : '0;
      k_first = (bus.mode == 2'b01) ? KW'(bus.n_coef) - KW'(1) : '0;
      cfg_bad = (bus.n_coef == '0) || (bus.n_samp == '0) || (bus.mode == 2'b11) ||
                ((bus.mode == 2'b01) && (bus.n_samp < OAW'(bus.n_coef)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         mode_r        <= '0;
         rnd_r         <= 1'b0;
         m_r           <= '0;
         n_r           <= '0;
         k             <= '0;
         j             <= '0;
         vld_p1        <= 1'b0;
         acc_p2        <= '0;
         bus.coef_addr <= '0;
         bus.samp_addr <= '0;
         bus.out_addr  <= '0;
         bus.out_data  <= '0;
         bus.out_wr    <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.err       <= 1'b0;
         bus.sat_cnt   <= '0;
      end else begin
         vld_p1     <= 1'b0;
         bus.out_wr <= 1'b0;
         bus.done   <= 1'b0;
         if (bus.abort) begin
            // Abort beats start in IDLE and squashes any write staged this cycle.
            state    <= S_IDLE;
            bus.busy <= 1'b0;
         end else begin
            case (state)
               S_IDLE: if (bus.start) begin
                  mode_r      <= bus.mode;
                  rnd_r       <= bus.round_en;
                  m_r         <= KW'(bus.n_coef);
                  n_r         <= KW'(bus.n_samp);
                  k           <= k_first;
                  bus.sat_cnt <= '0;
                  if (cfg_bad) begin
                     bus.err  <= 1'b1;
                     bus.done <= 1'b1;
                     state    <= S_DONE;
                  end else begin
                     bus.err  <= 1'b0;
                     bus.busy <= 1'b1;
                     state    <= S_SETUP;
                  end
               end
               S_SETUP: begin
                  j             <= JW'(lo_cur);
                  bus.coef_addr <= COEF_AW'(lo_cur);
                  bus.samp_addr <= SAMP_AW'(k - lo_cur);
                  acc_p2        <= '0;
                  state         <= S_ISSUE;
               end
               // p0: one coefficient/sample address pair per cycle
               S_ISSUE: begin
                  vld_p1 <= 1'b1;
                  if (vld_p1) acc_p2 <= sum_p2;
                  if (j == JW'(j_hi)) begin
                     state <= S_DRAIN;
                  end else begin
                     j             <= j + JW'(1);
                     bus.coef_addr <= COEF_AW'(j + JW'(1));
                     bus.samp_addr <= SAMP_AW'(k - KW'(j) - KW'(1));
                  end
               end
               S_DRAIN: begin
                  bus.out_data <= sat_dw(rnd_p2);
                  bus.out_addr <= OAW'(k - base);
                  bus.out_wr   <= 1'b1;
                  if (clamped(rnd_p2) && (bus.sat_cnt != 16'hFFFF))
                     bus.sat_cnt <= bus.sat_cnt + 16'd1;
                  state <= S_WRITE;
               end
               S_WRITE: begin
                  if (k == k_last) begin
                     bus.busy <= 1'b0;
                     bus.done <= 1'b1;
                     state    <= S_DONE;
                  end else begin
                     k             <= k_nxt;
                     j             <= JW'(lo_nxt);
                     bus.coef_addr <= COEF_AW'(lo_nxt);
                     bus.samp_addr <= SAMP_AW'(k_nxt - lo_nxt);
                     acc_p2        <= '0;
                     state         <= S_ISSUE;
                  end
               end
               S_DONE:  state <= S_IDLE;
               default: state <= S_IDLE;
            endcase
         end
      end
   end
endmodule
